// File: rtl/mm_pkg.sv
// Shared types and default widths for the banked load/read sequencer.
package mm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        READ = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_DATA_WIDTH      = 8;
    localparam int DEF_BANK_ID_WIDTH   = 3;
    localparam int DEF_BANK_ADDR_WIDTH = 3;
    localparam int DEF_PASS_WIDTH      = 8;

endpackage

// File: rtl/wrap_counter.sv
// Enabled up-counter that returns to zero after its terminal value.
module wrap_counter #(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = en && (cnt == term);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/bank_seq_ctrl.sv
// Loads a row-major matrix into column banks, then sweeps its rows
// a programmable number of passes through a valid/ready row stream.
module bank_seq_ctrl
    import mm_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int BANK_ID_WIDTH   = DEF_BANK_ID_WIDTH,
    parameter int BANK_ADDR_WIDTH = DEF_BANK_ADDR_WIDTH,
    parameter int PASS_WIDTH      = DEF_PASS_WIDTH
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [PASS_WIDTH-1:0]      rd_passes,
    output logic                       busy,
    output logic                       done,
    input  logic                       in_valid,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       in_ready,
    output logic                       bram_we,
    output logic [DATA_WIDTH-1:0]      bram_din,
    output logic [BANK_ID_WIDTH-1:0]   bram_w_id,
    output logic [BANK_ADDR_WIDTH-1:0] bram_w_addr,
    output logic [BANK_ADDR_WIDTH-1:0] bram_r_addr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BANK_ADDR_WIDTH-1:0] out_row,
    output logic                       out_last
);

    localparam logic [BANK_ID_WIDTH-1:0]   COL_TERM = '1;
    localparam logic [BANK_ADDR_WIDTH-1:0] ROW_TERM = '1;

    state_t state, state_nxt;

    logic                       clr;
    logic                       beat;
    logic                       issue;
    logic                       last_row;
    logic                       accept_last;
    logic                       issued_all;
    logic                       valid_q;
    logic                       last_q;
    logic [BANK_ADDR_WIDTH-1:0] row_q;
    logic [PASS_WIDTH-1:0]      pass_term;

    logic [BANK_ID_WIDTH-1:0]   col_cnt;
    logic [BANK_ADDR_WIDTH-1:0] wrow_cnt;
    logic [BANK_ADDR_WIDTH-1:0] rrow_cnt;
    logic [PASS_WIDTH-1:0]      pass_cnt;
    logic col_wrap, wrow_wrap, rrow_wrap, pass_wrap;

    assign clr         = (state == IDLE);
    assign beat        = in_valid && in_ready;
    assign issue       = (state == READ) && !issued_all
                         && (!valid_q || out_ready);
    assign last_row    = (rrow_cnt == ROW_TERM)
                         && (pass_cnt == pass_term);
    assign accept_last = valid_q && out_ready && last_q;

    wrap_counter #(.W(BANK_ID_WIDTH)) u_col (
        .clock(clock), .reset_n(reset_n), .clr(clr),
        .en(beat), .term(COL_TERM),
        .cnt(col_cnt), .wrap(col_wrap)
    );

    wrap_counter #(.W(BANK_ADDR_WIDTH)) u_wrow (
        .clock(clock), .reset_n(reset_n), .clr(clr),
        .en(col_wrap), .term(ROW_TERM),
        .cnt(wrow_cnt), .wrap(wrow_wrap)
    );

    wrap_counter #(.W(BANK_ADDR_WIDTH)) u_rrow (
        .clock(clock), .reset_n(reset_n), .clr(clr),
        .en(issue), .term(ROW_TERM),
        .cnt(rrow_cnt), .wrap(rrow_wrap)
    );

    wrap_counter #(.W(PASS_WIDTH)) u_pass (
        .clock(clock), .reset_n(reset_n), .clr(clr),
        .en(rrow_wrap), .term(pass_term),
        .cnt(pass_cnt), .wrap(pass_wrap)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        in_ready  = 1'b0;
        unique case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (wrow_wrap) state_nxt = READ;
            end
            READ: begin
                busy = 1'b1;
                if (accept_last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A zero pass count still performs one sweep.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pass_term <= '0;
        end else if (clr && start) begin
            pass_term <= (rd_passes == '0) ? '0
                       : rd_passes - PASS_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            issued_all <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            row_q      <= '0;
        end else begin
            if (clr) begin
                issued_all <= 1'b0;
            end else if (pass_wrap) begin
                issued_all <= 1'b1;
            end
            if (issue) begin
                valid_q <= 1'b1;
                last_q  <= last_row;
                row_q   <= rrow_cnt;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bram_we     = beat;
    assign bram_din    = in_data;
    assign bram_w_id   = col_cnt;
    assign bram_w_addr = wrow_cnt;

    // Re-present the shown row when stalled so BRAM output holds.
    assign bram_r_addr = issue ? rrow_cnt : row_q;
    assign out_valid   = valid_q;
    assign out_row     = row_q;
    assign out_last    = valid_q && last_q;

endmodule

// File: tb/tb_bank_seq_ctrl.sv
// Randomized bench for bank_seq_ctrl with a behavioural matrix/row model.
module tb_bank_seq_ctrl;

    localparam int DW = 8;
    localparam int IW = 3;
    localparam int AW = 3;
    localparam int PW = 8;
    localparam int NB = 8;
    localparam int NS = 8;
    localparam int NE = NB * NS;

    logic          clock;
    logic          reset_n;
    logic          start;
    logic [PW-1:0] rd_passes;
    logic          busy;
    logic          done;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          bram_we;
    logic [DW-1:0] bram_din;
    logic [IW-1:0] bram_w_id;
    logic [AW-1:0] bram_w_addr;
    logic [AW-1:0] bram_r_addr;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_row;
    logic          out_last;

    int total;
    int bad;

    logic [DW-1:0] elem [NE];
    logic [DW-1:0] mem  [NB][NS];
    logic [DW-1:0] rdq  [NB];

    bank_seq_ctrl #(
        .DATA_WIDTH(DW), .BANK_ID_WIDTH(IW),
        .BANK_ADDR_WIDTH(AW), .PASS_WIDTH(PW)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .start(start), .rd_passes(rd_passes),
        .busy(busy), .done(done),
        .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready),
        .bram_we(bram_we), .bram_din(bram_din),
        .bram_w_id(bram_w_id), .bram_w_addr(bram_w_addr),
        .bram_r_addr(bram_r_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_last(out_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One-cycle-latency BRAM bank model, read-before-write.
    always @(posedge clock) begin
        for (int b = 0; b < NB; b++) begin
            rdq[b] <= mem[b][bram_r_addr];
            if (bram_we && (int'(bram_w_id) == b))
                mem[b][bram_w_addr] <= bram_din;
        end
    end

    task automatic run_sequence(input int passes, input int vmode,
                                input int rmode, input int stall_row,
                                input bit glitch, output int stalls,
                                output int dones);
        int k, idx, n, np, cyc;
        int rows[$];
        bit exp_valid;
        logic [AW-1:0] exp_r;
        np = (passes == 0) ? 1 : passes;
        n = np * NS;
        rows.delete();
        for (int p = 0; p < np; p++)
            for (int r = 0; r < NS; r++) rows.push_back(r);
        for (int e = 0; e < NE; e++)
            elem[e] = (vmode == 0) ? DW'(e) : DW'($urandom);
        stalls = 0;
        dones = 0;

        @(negedge clock);
        start = 1'b1;
        rd_passes = PW'(passes);
        #1;
        total++;
        if (busy !== 1'b0)
            $display("FAIL idle_busy got=%b want=0", busy);
        @(negedge clock);
        start = 1'b0;
        k = 0;
        cyc = 0;
        while (k < NE && cyc < 1000) begin
            if (vmode == 0) in_valid = 1'b1;
            else if (vmode == 1) in_valid = (cyc % 2 == 0);
            else in_valid = ($urandom_range(0, 2) != 0);
            in_data = elem[k];
            #1;
            total++;
            if (in_ready !== 1'b1 || busy !== 1'b1) begin
                bad++;
                $display("FAIL load_ready got=%b%b want=11",
                         in_ready, busy);
            end
            total++;
            if (bram_we !== in_valid) begin
                bad++;
                $display("FAIL load_we beat=%0d got=%b want=%b",
                         k, bram_we, in_valid);
            end
            if (in_valid) begin
                total++;
                if (bram_w_id !== IW'(k % NB) ||
                    bram_w_addr !== AW'(k / NB) ||
                    bram_din !== elem[k]) begin
                    bad++;
                    $display("FAIL load_write beat=%0d got=%0d/%0d/%h want=%0d/%0d/%h",
                             k, bram_w_id, bram_w_addr, bram_din,
                             k % NB, k / NB, elem[k]);
                end
                k++;
            end
            cyc++;
            @(negedge clock);
        end
        in_valid = 1'b0;
        total++;
        if (k < NE) begin
            bad++;
            $display("FAIL load_timeout got=%0d want=%0d", k, NE);
        end

        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 2000) begin
            exp_valid = (cyc > 0);
            if (rmode == 0) out_ready = 1'b1;
            else out_ready = ($urandom_range(0, 3) != 0);
            if (stall_row >= 0 && exp_valid && idx < NS &&
                rows[idx] == stall_row && stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
            end
            start = glitch && (cyc == 5);
            #1;
            if (cyc == 0) begin
                total++;
                if (in_ready !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL read_entry got=%b%b want=01",
                             in_ready, busy);
                end
            end
            total++;
            if (bram_we !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("FAIL read_quiet got=%b%b want=00",
                         bram_we, done);
            end
            if (!exp_valid) exp_r = AW'(rows[0]);
            else if (!out_ready) exp_r = AW'(rows[idx]);
            else if (idx + 1 < n) exp_r = AW'(rows[idx + 1]);
            else exp_r = AW'(rows[idx]);
            total++;
            if (bram_r_addr !== exp_r) begin
                bad++;
                $display("FAIL read_addr cyc=%0d got=%0d want=%0d",
                         cyc, bram_r_addr, exp_r);
            end
            total++;
            if (out_valid !== exp_valid) begin
                bad++;
                $display("FAIL out_valid cyc=%0d got=%b want=%b",
                         cyc, out_valid, exp_valid);
            end
            if (exp_valid) begin
                total++;
                if (out_row !== AW'(rows[idx]) ||
                    out_last !== (idx == n - 1)) begin
                    bad++;
                    $display("FAIL out_row idx=%0d got=%0d/%b want=%0d/%b",
                             idx, out_row, out_last, rows[idx],
                             idx == n - 1);
                end
                for (int b = 0; b < NB; b++) begin
                    total++;
                    if (rdq[b] !== elem[rows[idx] * NB + b]) begin
                        bad++;
                        $display("FAIL row_data row=%0d bank=%0d got=%h want=%h",
                                 rows[idx], b, rdq[b],
                                 elem[rows[idx] * NB + b]);
                    end
                end
                if (out_ready) idx++;
            end
            cyc++;
            @(negedge clock);
        end
        start = 1'b0;
        total++;
        if (idx < n) begin
            bad++;
            $display("FAIL read_timeout got=%0d want=%0d", idx, n);
        end
        #1;
        if (done === 1'b1) dones++;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse got=%b%b%b want=100",
                     done, busy, out_valid);
        end
        @(negedge clock);
        #1;
        if (done === 1'b1) dones++;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL after_done got=%b%b%b want=000",
                     done, busy, in_ready);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        rd_passes = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        #1;
        total++;
        if ({busy, done, in_ready, bram_we, out_valid, out_last} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=000000",
                     {busy, done, in_ready, bram_we, out_valid, out_last});
        end
        total++;
        if ({bram_w_id, bram_w_addr, bram_r_addr, out_row} !== '0) begin
            bad++;
            $display("FAIL reset_addr got=%h want=0",
                     {bram_w_id, bram_w_addr, bram_r_addr, out_row});
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        int st, dn;
        run_sequence(2, 0, 0, -1, 1'b0, st, dn);
        total++;
        if (dn != 1) begin
            bad++;
            $display("FAIL b2b_done got=%0d want=1", dn);
        end
    endtask

    task automatic test_toggle_valid();
        int st, dn;
        run_sequence(1, 1, 0, -1, 1'b0, st, dn);
    endtask

    task automatic test_stall();
        int st, dn;
        run_sequence(1, 2, 0, 4, 1'b0, st, dn);
        total++;
        if (st != 3) begin
            bad++;
            $display("FAIL stall_cycles got=%0d want=3", st);
        end
    endtask

    task automatic test_zero_passes();
        int st, dn;
        run_sequence(0, 2, 0, -1, 1'b0, st, dn);
    endtask

    task automatic test_start_in_read();
        int st, dn;
        run_sequence(2, 2, 1, -1, 1'b1, st, dn);
        total++;
        if (dn != 1) begin
            bad++;
            $display("FAIL glitch_done got=%0d want=1", dn);
        end
        repeat (3) begin
            @(negedge clock);
            #1;
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL glitch_idle got=%b want=0", busy);
            end
        end
    endtask

    task automatic test_random_ready();
        int st, dn;
        run_sequence(3, 2, 1, -1, 1'b0, st, dn);
    endtask

    task automatic test_reset_mid_load();
        int st, dn;
        @(negedge clock);
        start = 1'b1;
        rd_passes = 8'd1;
        @(negedge clock);
        start = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_data = DW'(k + 100);
            @(negedge clock);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({busy, done, in_ready, bram_we, out_valid, out_last} !== 6'b0) begin
            bad++;
            $display("FAIL midreset_flags got=%b want=000000",
                     {busy, done, in_ready, bram_we, out_valid, out_last});
        end
        total++;
        if ({bram_w_id, bram_w_addr, bram_r_addr, out_row} !== '0) begin
            bad++;
            $display("FAIL midreset_addr got=%h want=0",
                     {bram_w_id, bram_w_addr, bram_r_addr, out_row});
        end
        @(negedge clock);
        in_valid = 1'b0;
        reset_n = 1'b1;
        run_sequence(1, 0, 0, -1, 1'b0, st, dn);
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_back_to_back();
        test_toggle_valid();
        test_stall();
        test_zero_passes();
        test_start_in_read();
        test_random_ready();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bank_seq_ctrl.md
BANK_SEQ_CTRL -- requirements
Module: bank_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, element width.
REQ-002 SHALL have parameter BANK_ID_WIDTH, default 3; BANK_CNT = 2**BANK_ID_WIDTH matrix columns, one per bank.
REQ-003 SHALL have parameter BANK_ADDR_WIDTH, default 3; BANK_SIZE = 2**BANK_ADDR_WIDTH matrix rows, one per bank address.
REQ-004 SHALL have parameter PASS_WIDTH, default 8, width of the read-pass count.
REQ-005 Ports SHALL be:
clock  in  1  sole clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  begin load-then-read sequence; sampled only in IDLE
rd_passes  in  PASS_WIDTH  number of full row sweeps; latched at start
busy  out  1  high in LOAD and READ
done  out  1  one-cycle pulse when sequence completes
in_valid  in  1  load stream valid
in_data  in  DATA_WIDTH  load element, row-major order
in_ready  out  1  load stream ready
bram_we  out  1  bank write enable
bram_din  out  DATA_WIDTH  write data
bram_w_id  out  BANK_ID_WIDTH  write bank select
bram_w_addr  out  BANK_ADDR_WIDTH  write address
bram_r_addr  out  BANK_ADDR_WIDTH  read address, common to all banks
out_valid  out  1  qualifies the BRAM row output (1-cycle read latency)
out_ready  in  1  consumer accepts the current row
out_row  out  BANK_ADDR_WIDTH  row index of the row qualified by out_valid
out_last  out  1  current row is the last row of the last pass

Function
REQ-006 SHALL implement FSM states IDLE, LOAD, READ, DONE; reset state IDLE.
REQ-007 IDLE -> LOAD on start=1; SHALL latch rd_passes, treating 0 as 1; start in any other state SHALL be ignored.
REQ-008 In LOAD, in_ready SHALL be 1; accepted beat = in_valid & in_ready.
REQ-009 Each accepted beat SHALL drive, combinationally in the same cycle, bram_we=1, bram_din=in_data, bram_w_id=column counter, bram_w_addr=row counter.
REQ-010 Column counter SHALL wrap BANK_CNT-1 -> 0 and increment the row counter on wrap; cycles without an accepted beat SHALL change no counter.
REQ-011 After beat BANK_CNT*BANK_SIZE is accepted, the FSM SHALL enter READ on the next cycle; bram_we SHALL be 0 outside accepted beats.
REQ-012 In READ, a row issue SHALL occur when rows remain and (out_valid=0 or out_ready=1); bram_r_addr SHALL equal the issued row address in the cycle of issue.
REQ-013 When no issue occurs, bram_r_addr SHALL equal the row currently shown, so BRAM output stays stable under backpressure.
REQ-014 out_valid SHALL be registered: set the cycle after an issue, cleared on out_ready=1 with no issue in the same cycle.
REQ-015 out_row SHALL equal the row address issued one cycle earlier; rows SHALL sweep 0..BANK_SIZE-1, repeated for the latched pass count.
REQ-016 out_last SHALL be 1 only when out_valid=1 on row BANK_SIZE-1 of the final pass.
REQ-017 Acceptance of the out_last row SHALL move the FSM to DONE; DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-018 The first READ issue SHALL occur the cycle after the final write, so read data reflects all written elements.
REQ-019 busy SHALL be 1 in LOAD and READ, 0 in IDLE and DONE.

Reset
REQ-020 reset_n=0 SHALL asynchronously force state IDLE and all counters to 0, and busy, done, in_ready, bram_we, out_valid and out_last to 0; bram_w_id, bram_w_addr, bram_r_addr and out_row SHALL read 0.
REQ-021 Reset asserted mid-LOAD or mid-READ SHALL abort the sequence with no further writes; the next start SHALL restart from element 0.

Structure
REQ-022 The FSM state enum and default width constants SHALL reside in shared package mm_pkg.
REQ-023 Column, row and pass counters SHALL reuse one sub-module, wrap_counter (enable, terminal value, wrap flag).

Verification (BANK_CNT=8, BANK_SIZE=8)
REQ-024 start, rd_passes=2, 64 back-to-back beats with value k -> write k lands at bank k%8, addr k/8; out_ready=1 gives 16 consecutive valid rows 0..7,0..7, out_last on the 16th, done one cycle later.
REQ-025 in_valid toggled 1/0 during LOAD -> exactly 64 writes, counters frozen on idle cycles, READ entered the cycle after the 64th write.
REQ-026 out_ready held 0 for 3 cycles on row 4 -> bram_r_addr=4 and out_row=4 held; BRAM row unchanged; row 5 follows the release with no row lost or duplicated.
REQ-027 rd_passes=0 -> exactly 8 rows, out_last on row 7.
REQ-028 start pulsed during READ -> ignored; the sequence completes unchanged with a single done pulse.
REQ-029 reset_n low after beat 20 -> all outputs 0 immediately; the next start writes element 0 at bank 0, addr 0.
